// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the shared memory port: fetch requester, data requester
// and the memory side. The arbiter binds the slave view; whoever drives the
// requesters and models the memory binds the master view.
interface mem_port_arbiter_if;
    // Valid/ready contract: a requester raises *_req with stable address/data
    // and holds it until the matching *_ack (or if_kill for fetch); *_ack is a
    // single-cycle pulse, and *_rdata is meaningful only in that ack cycle.
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic [3:0]  dm_wen;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_kill,
        input  dm_req, dm_wen, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_ack, if_rdata,
        output dm_ack, dm_rdata,
        output mem_en, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, if_kill,
        output dm_req, dm_wen, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_ack, if_rdata,
        input  dm_ack, dm_rdata,
        input  mem_en, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one non-pipelined synchronous memory port between
// instruction fetch (IF) and load/store data access (DM). DM wins by
// default; a starvation counter hands the port to IF after STARVE_MAX
// consecutive DM grants taken while IF was waiting.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic [1:0]          dbg_state,
    output logic                dbg_owner,
    output logic                dbg_killed,
    output logic [3:0]          dbg_starve_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic       OWNER_DM   = 1'b0;
    localparam logic       OWNER_IF   = 1'b1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        killed_q, killed_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        mem_en_q, mem_en_d;
    logic [3:0]  mem_wen_q, mem_wen_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        if_ok;
    logic        grant_if;
    logic        grant_dm;

    // Next-state, grant decision and port-register loading.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        killed_d     = killed_q;
        starve_cnt_d = starve_cnt_q;
        mem_en_d     = mem_en_q;
        mem_wen_d    = mem_wen_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        // A fetch being killed this cycle is not a candidate for the port.
        if_ok    = bus.if_req && !bus.if_kill;
        grant_if = if_ok && (!bus.dm_req || (starve_cnt_q == STARVE_LIM));
        grant_dm = bus.dm_req && !grant_if;

        case (state_q)
            S_IDLE: begin
                if (grant_if) begin
                    state_d      = S_ISSUE;
                    owner_d      = OWNER_IF;
                    killed_d     = 1'b0;
                    starve_cnt_d = 4'd0;
                    mem_en_d     = 1'b1;
                    mem_wen_d    = 4'b0000;
                    mem_addr_d   = bus.if_addr;
                end else if (grant_dm) begin
                    state_d      = S_ISSUE;
                    owner_d      = OWNER_DM;
                    killed_d     = 1'b0;
                    mem_en_d     = 1'b1;
                    mem_wen_d    = bus.dm_wen;
                    mem_addr_d   = bus.dm_addr;
                    mem_wdata_d  = bus.dm_wdata;
                    // Raw if_req: a waiting fetch counts as starved.
                    if (bus.if_req && (starve_cnt_q < STARVE_LIM)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end
            end
            S_ISSUE: begin
                state_d   = S_RESP;
                mem_en_d  = 1'b0;
                mem_wen_d = 4'b0000;
                if ((owner_q == OWNER_IF) && bus.if_kill) begin
                    killed_d = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if ((owner_q == OWNER_IF) && bus.if_kill) begin
                    killed_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_en_d  = 1'b0;
                mem_wen_d = 4'b0000;
            end
        endcase
    end

    // State and port registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWNER_DM;
            killed_q     <= 1'b0;
            starve_cnt_q <= 4'd0;
            mem_en_q     <= 1'b0;
            mem_wen_q    <= 4'b0000;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            killed_q     <= killed_d;
            starve_cnt_q <= starve_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Acks decode from registered state; a kill arriving in the response
    // cycle itself also suppresses if_ack. Read data is a plain pass-through.
    always_comb begin
        bus.mem_en    = mem_en_q && !rst;
        bus.mem_wen   = mem_wen_q;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        bus.if_ack    = !rst && (state_q == S_RESP) && (owner_q == OWNER_IF)
                        && !killed_q && !bus.if_kill;
        bus.dm_ack    = !rst && (state_q == S_RESP) && (owner_q == OWNER_DM);
        bus.if_rdata  = bus.mem_rdata;
        bus.dm_rdata  = bus.mem_rdata;
    end

    assign dbg_state      = state_q;
    assign dbg_owner      = owner_q;
    assign dbg_killed     = killed_q;
    assign dbg_starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store/load, contention with
// starvation hand-over, kill, reset mid-access and a single-byte store.
module tb_mem_port_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    logic       dbg_owner;
    logic       dbg_killed;
    logic [3:0] dbg_starve_cnt;

    int checks;
    int failures;

    // Free-running event counters sampled away from the active edge.
    int mem_en_cnt;
    int if_ack_cnt;
    int dm_ack_cnt;
    int wen_cnt;
    int both_ack_cnt;
    int port_violation_cnt;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .dbg_state      (dbg_state),
        .dbg_owner      (dbg_owner),
        .dbg_killed     (dbg_killed),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    // Clock: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Per-cycle monitor on the falling edge.
    initial begin
        mem_en_cnt = 0; if_ack_cnt = 0; dm_ack_cnt = 0;
        wen_cnt = 0; both_ack_cnt = 0; port_violation_cnt = 0;
    end
    always @(negedge clk) begin
        if (bus.mem_en) mem_en_cnt++;
        if (bus.if_ack) if_ack_cnt++;
        if (bus.dm_ack) dm_ack_cnt++;
        if (bus.mem_wen != 4'b0000) wen_cnt++;
        if (bus.if_ack && bus.dm_ack) both_ack_cnt++;
        if (bus.mem_en && dbg_state != 2'd1) port_violation_cnt++;
        if ((bus.mem_wen != 4'b0000) && !(dbg_state == 2'd1 && dbg_owner == 1'b0))
            port_violation_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int en0, ia0, da0, w0;
    logic [31:0] exp_addr;
    logic        exp_owner;
    logic [3:0]  exp_starve;
    logic        grant_if_seq [6];
    logic [3:0]  starve_seq [6];

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.if_kill = 1'b0;
        bus.dm_req = 1'b0; bus.dm_wen = 4'b0; bus.dm_addr = 32'd0; bus.dm_wdata = 32'd0;
        bus.mem_rdata = 32'd0;

        // ---- reset state ----
        tick(); tick();
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_owner", 32'(dbg_owner), 32'd0);
        chk("rst_starve", 32'(dbg_starve_cnt), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_acks", {30'd0, bus.if_ack, bus.dm_ack}, 32'd0);
        rst = 1'b0;
        tick();

        // ---- single fetch ----
        bus.if_req = 1'b1; bus.if_addr = 32'hBFC0_0000;
        tick();
        chk("f_mem_en", 32'(bus.mem_en), 32'd1);
        chk("f_mem_addr", bus.mem_addr, 32'hBFC0_0000);
        chk("f_mem_wen", 32'(bus.mem_wen), 32'd0);
        chk("f_no_ack_issue", {30'd0, bus.if_ack, bus.dm_ack}, 32'd0);
        bus.mem_rdata = 32'h2408_0001;
        tick();
        chk("f_if_ack", 32'(bus.if_ack), 32'd1);
        chk("f_if_rdata", bus.if_rdata, 32'h2408_0001);
        chk("f_dm_ack", 32'(bus.dm_ack), 32'd0);
        chk("f_resp_mem_en", 32'(bus.mem_en), 32'd0);
        tick();
        bus.if_req = 1'b0;
        chk("f_back_idle", 32'(dbg_state), 32'd0);
        chk("f_idle_ack", {30'd0, bus.if_ack, bus.dm_ack}, 32'd0);
        tick();
        chk("f_stays_idle", 32'(dbg_state), 32'd0);

        // ---- store then load held back-to-back ----
        bus.dm_req = 1'b1; bus.dm_wen = 4'hF; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEAD_BEEF;
        tick();
        chk("st_mem_wen", 32'(bus.mem_wen), 32'hF);
        chk("st_mem_addr", bus.mem_addr, 32'h100);
        chk("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("st_mem_en", 32'(bus.mem_en), 32'd1);
        tick();
        chk("st_dm_ack", 32'(bus.dm_ack), 32'd1);
        chk("st_if_ack", 32'(bus.if_ack), 32'd0);
        chk("st_resp_wen", 32'(bus.mem_wen), 32'd0);
        bus.dm_wen = 4'h0;
        tick();
        chk("ld_idle", 32'(dbg_state), 32'd0);
        chk("ld_idle_ack", 32'(bus.dm_ack), 32'd0);
        tick();
        chk("ld_mem_en", 32'(bus.mem_en), 32'd1);
        chk("ld_mem_wen", 32'(bus.mem_wen), 32'd0);
        chk("ld_mem_addr", bus.mem_addr, 32'h100);
        bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("ld_dm_ack", 32'(bus.dm_ack), 32'd1);
        chk("ld_dm_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
        tick();
        bus.dm_req = 1'b0;
        chk("ld_starve_unchanged", 32'(dbg_starve_cnt), 32'd0);
        tick();

        // ---- contention: DM,DM,DM,DM,IF,DM ----
        grant_if_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        starve_seq   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        bus.dm_req = 1'b1; bus.dm_wen = 4'h0; bus.dm_addr = 32'h80;
        for (int g = 0; g < 6; g++) begin
            exp_owner  = grant_if_seq[g];
            exp_addr   = exp_owner ? 32'h40 : 32'h80;
            exp_starve = starve_seq[g];
            tick();
            chk($sformatf("ct%0d_owner", g), 32'(dbg_owner), 32'(exp_owner));
            chk($sformatf("ct%0d_addr", g), bus.mem_addr, exp_addr);
            chk($sformatf("ct%0d_starve", g), 32'(dbg_starve_cnt), 32'(exp_starve));
            tick();
            chk($sformatf("ct%0d_acks", g), {30'd0, bus.if_ack, bus.dm_ack},
                exp_owner ? 32'd2 : 32'd1);
            tick();
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        tick();

        // ---- kill during ISSUE, then re-fetch at 0x200 ----
        en0 = mem_en_cnt; ia0 = if_ack_cnt;
        bus.if_req = 1'b1; bus.if_addr = 32'h180;
        tick();
        chk("k_mem_en", 32'(bus.mem_en), 32'd1);
        chk("k_mem_addr", bus.mem_addr, 32'h180);
        bus.if_kill = 1'b1; bus.if_req = 1'b0;
        tick();
        bus.if_kill = 1'b0;
        #1;
        chk("k_no_if_ack", 32'(bus.if_ack), 32'd0);
        chk("k_killed_flag", 32'(dbg_killed), 32'd1);
        tick();
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        tick();
        chk("k2_mem_addr", bus.mem_addr, 32'h200);
        bus.mem_rdata = 32'h3C1D_A000;
        tick();
        chk("k2_if_ack", 32'(bus.if_ack), 32'd1);
        chk("k2_if_rdata", bus.if_rdata, 32'h3C1D_A000);
        tick();
        bus.if_req = 1'b0;
        tick();
        chk("k_mem_en_pulses", 32'(mem_en_cnt - en0), 32'd2);
        chk("k_if_ack_count", 32'(if_ack_cnt - ia0), 32'd1);

        // ---- reset in ISSUE of a DM store ----
        da0 = dm_ack_cnt;
        bus.if_req = 1'b1; bus.if_addr = 32'h400;
        bus.dm_req = 1'b1; bus.dm_wen = 4'hF; bus.dm_addr = 32'h300; bus.dm_wdata = 32'h1234_5678;
        tick();
        chk("r_mem_en_before", 32'(bus.mem_en), 32'd1);
        chk("r_starve_before", 32'(dbg_starve_cnt), 32'd1);
        rst = 1'b1;
        #1;
        chk("r_mem_en_forced", 32'(bus.mem_en), 32'd0);
        chk("r_dm_ack_forced", 32'(bus.dm_ack), 32'd0);
        bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.dm_wen = 4'h0;
        tick();
        rst = 1'b0;
        chk("r_state", 32'(dbg_state), 32'd0);
        chk("r_starve", 32'(dbg_starve_cnt), 32'd0);
        chk("r_mem_addr", bus.mem_addr, 32'd0);
        chk("r_mem_wen", 32'(bus.mem_wen), 32'd0);
        tick(); tick(); tick();
        chk("r_no_stale_ack", 32'(dm_ack_cnt - da0), 32'd0);
        chk("r_idle_after", 32'(dbg_state), 32'd0);

        // ---- single-byte store ----
        w0 = wen_cnt;
        bus.dm_req = 1'b1; bus.dm_wen = 4'b0010; bus.dm_addr = 32'h104; bus.dm_wdata = 32'h0000_AB00;
        tick();
        chk("b_mem_wen", 32'(bus.mem_wen), 32'h2);
        chk("b_mem_addr", bus.mem_addr, 32'h104);
        tick();
        chk("b_resp_wen", 32'(bus.mem_wen), 32'd0);
        chk("b_dm_ack", 32'(bus.dm_ack), 32'd1);
        bus.dm_wen = 4'h0;
        tick();
        bus.dm_req = 1'b0;
        chk("b_idle_wen", 32'(bus.mem_wen), 32'd0);
        tick(); tick();
        chk("b_wen_cycles", 32'(wen_cnt - w0), 32'd1);

        // ---- whole-run invariants ----
        chk("never_both_acks", 32'(both_ack_cnt), 32'd0);
        chk("port_only_in_issue", 32'(port_violation_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single synchronous memory port between instruction fetch (IF) and the data-memory access of load/store instructions (DM). Each requester holds a request until acknowledged; one non-pipelined access runs at a time. DM wins by default; a starvation counter guarantees IF forward progress. The block sits between the fetch/memory stages of the CPU and the 32-bit byte-writable memory driven by the control unit's MemEn/MemWrite decode.

## Interface
- STARVE_MAX, 4: consecutive DM grants made while IF was waiting, after which the next arbitration goes to IF (range 1..15).
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_ack or if_kill
- if_addr  in  32  fetch byte address, stable while if_req=1
- if_kill  in  1  cancel outstanding fetch (taken branch/jump)
- if_ack  out  1  fetch complete, if_rdata valid this cycle
- if_rdata  out  32  fetched instruction
- dm_req  in  1  data request, held until dm_ack
- dm_wen  in  4  byte write enables; 4'b0000 = load
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_ack  out  1  data access complete; dm_rdata valid for loads
- dm_rdata  out  32  load data
- mem_en  out  1  memory port enable
- mem_wen  out  4  memory byte write enables
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_en

## Operation
- FSM states: IDLE, ISSUE, RESP. Register `owner` (IF/DM) latched at grant.
- IDLE: if either req=1 (and, for IF, if_kill=0), grant, latch owner and requester's addr/wen/wdata into mem_* registers, go ISSUE. Else stay.
- Grant rule: only one requesting → it wins. Both → DM wins unless starve_cnt == STARVE_MAX, then IF wins.
- starve_cnt: +1 on DM grant while if_req=1 (saturates at STARVE_MAX); cleared on any IF grant; unchanged otherwise.
- ISSUE: mem_en=1, mem_* = latched values; IF grant always drives mem_wen=0. Go RESP.
- RESP: mem_en=0, mem_wen=0. Owner's ack=1; {if,dm}_rdata = mem_rdata (combinational pass-through, both buses carry mem_rdata, only ack qualifies). Go IDLE. Request inputs not sampled in RESP.
- if_kill: if owner=IF and if_kill=1 in ISSUE or RESP (sticky flag `killed`), if_ack is suppressed in RESP; the memory read still completes. In IDLE, if_kill=1 blocks IF grant that cycle. No effect on DM transactions.
- Stores: dm_ack in RESP; dm_rdata don't-care.
- Reset: state=IDLE, owner=DM, killed=0, starve_cnt=0, mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0. if_ack, dm_ack, mem_en additionally forced 0 combinationally while rst=1. Reset mid-transaction abandons it: no ack is ever given for it.

## Timing
- Access latency: req seen in IDLE at cycle N → mem_en=1 in N+1 → ack in N+2 → IDLE in N+3.
- Requester may drop req or present a new request in cycle N+3 (the cycle after ack); max throughput one access per 3 cycles.
- Back-to-back: request held continuously after ack is re-granted as a new access in N+3; requesters must deassert in the cycle after ack unless a new access is intended.
- Exactly one ack per granted, un-killed, un-reset transaction; never both acks in one cycle.
- mem_en never asserted outside ISSUE; mem_wen nonzero only in ISSUE with owner=DM.

## Test plan
- Single fetch: rst 2 cycles, if_req=1, if_addr=0xBFC00000, mem_rdata=0x24080001 in RESP → mem_en=1,mem_addr=0xBFC00000,mem_wen=0 at N+1; if_ack=1,if_rdata=0x24080001 at N+2; dm_ack=0 throughout.
- Store then load: dm_req, dm_wen=4'b1111, dm_addr=0x100, dm_wdata=0xDEADBEEF → mem_wen=4'hF at N+1, dm_ack at N+2; then load 0x100 with mem_rdata=0xDEADBEEF → mem_wen=0, dm_ack at N+5 with dm_rdata=0xDEADBEEF.
- Contention/starvation (STARVE_MAX=4): if_req and dm_req held continuously, re-issued after every ack → grant order DM,DM,DM,DM,IF,DM,… ; starve_cnt 0→4 then 0 after IF grant.
- Kill: IF granted, if_kill=1 for one cycle during ISSUE → no if_ack in RESP, mem_en still pulsed once; IF re-request with new addr 0x200 completes normally 3 cycles later.
- Reset mid-op: rst=1 in ISSUE of a DM store → mem_en=0 and dm_ack=0 in that cycle; after release state IDLE, starve_cnt=0, mem_addr=0, no stale ack.
- Byte store: dm_wen=4'b0010, dm_addr=0x104 → mem_wen=4'b0010, mem_addr=0x104 exactly one cycle; mem_wen=0 all other cycles.
